controlador_escritura_rtc: RTL
==============================

Name: controlador_escritura_rtc

Overview:
- Sequences the transfer of user-configured values (hour, date or timer groups) from the configuration counters into the RTC register map.
- On a commit pulse it snapshots the active group, then issues one bus write per field, followed by a group-specific transfer command.
- Sits between the configuration counters and the RTC bus driver (parallel address/data write handshake). Provides busy/done status to the top-level FSM.

Parameters:
- CMD_ADDR, 8'hF1: command register address written after each group.
- CMD_HORA_FECHA, 8'hD0: command byte after hour or date group.
- CMD_TIMER, 8'hE0: command byte after timer group.
- TIMEOUT_CYCLES, 1023: wr_done watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- commit  in  1  level; rising edge requests write of current group
- config_mode  in  2  0 normal, 1 hour, 2 date, 3 timer
- btn_data_SS, btn_data_MM, btn_data_HH  in  8 each  hour fields, BCD
- AM_PM  in  1  1 = PM
- btn_data_DAY, btn_data_MES, btn_data_YEAR  in  8 each  date fields, BCD
- dia_semana  in  8  weekday code
- btn_data_SS_T, btn_data_MM_T, btn_data_HH_T  in  8 each  timer fields, BCD
- wr_req  out  1  write request to bus driver
- wr_addr  out  8  RTC register address
- wr_data  out  8  RTC register data
- wr_done  in  1  one-cycle pulse; driver finished current write
- busy  out  1  sequence in progress
- seq_done  out  1  one-cycle pulse at end of sequence
- seq_err  out  1  sticky timeout flag; constant 0 without the optional feature

Behaviour:
- Reset values:
  - wr_req=0, wr_addr=0, wr_data=0, busy=0, seq_done=0, seq_err=0.
  - FSM in IDLE; index=0; commit edge register=0.
- Commit detection: commit_tick = commit & ~commit_reg, where commit_reg is registered every cycle.
- IDLE:
  - On commit_tick with config_mode != 0: latch group = config_mode and snapshot all field inputs. Go to LOAD; busy=1 from the next cycle.
  - commit_tick with config_mode == 0 is ignored.
- Write sequences (group, index → addr, data):
  - hour: 0→21h SS; 1→22h MM; 2→23h {1'b1, 1'b0, AM_PM_snap, HH_snap[4:0]}.
  - date: 0→24h DAY; 1→25h MES; 2→26h YEAR; 3→27h dia_semana.
  - timer: 0→41h SS_T; 1→42h MM_T; 2→43h HH_T.
- LOAD: drive wr_addr/wr_data from the table, set wr_req=1, go to WAIT.
- WAIT:
  - Hold wr_req, wr_addr and wr_data stable until wr_done.
  - On wr_done: drop wr_req in the same edge.
  - If the entry was the last for the group, go to CMD. Otherwise index+1 and go to LOAD.
  - A minimum of one idle cycle separates requests.
- CMD: wr_addr=CMD_ADDR; wr_data=CMD_TIMER if group 3, else CMD_HORA_FECHA. wr_req=1, then go to CMD_WAIT.
- CMD_WAIT: on wr_done drop wr_req and go to FIN.
- FIN: seq_done=1 for exactly one cycle, busy=0, index=0, go to IDLE.
- Latency: hour/timer = 4 writes, date = 5 writes. Each write takes (1 + driver latency) cycles in WAIT plus 1 LOAD cycle.
- Boundary conditions:
  - commit_tick while busy is ignored, not queued.
  - Input or config_mode changes while busy have no effect; the snapshot is used.
  - wr_done in IDLE, LOAD, CMD or FIN is ignored.
  - wr_done on the same edge as reset: reset wins.
  - Reset mid-sequence: wr_req drops on the next edge with no partial command. seq_done is not pulsed; seq_err is cleared.
- seq_err is cleared only by reset, or by a new accepted commit.

Optional Feature:
- Macro: CONTROLADOR_RTC_TIMEOUT_EN.
- Enabled:
  - An 10-bit counter runs in WAIT and CMD_WAIT and clears on each state entry.
  - On reaching TIMEOUT_CYCLES without wr_done: drop wr_req, set seq_err=1, go to IDLE without a seq_done pulse.
- Disabled: no counter is built; seq_err is tied to 0; the FSM waits indefinitely.

Decomposition:
- Shared package/include (rtc_defs):
  - Register addresses 21h–27h and 41h–43h.
  - CMD_ADDR and command byte defaults.
  - config_mode encodings.
  - State encodings.
- Sub-module secuencia_escritura_rtc: purely combinational table. Inputs: group, index, snapshot fields. Outputs: addr, data, last.
- The controller contains the FSM, snapshot registers, edge detect and watchdog.

Test Plan:
- Hour group: mode=1, SS=8'h45, MM=8'h30, HH=8'h11, AM_PM=1, commit; driver acks after 3 cycles → writes (21h,45h), (22h,30h), (23h,B1h), (F1h,D0h); then one seq_done pulse; busy low.
- Date group: mode=2, DAY=8'h15, MES=8'h04, YEAR=8'h16, dia_semana=8'h05 → writes 24h/15h, 25h/04h, 26h/16h, 27h/05h, F1h/D0h, in order.
- Timer group with mode and fields changed after commit → the snapshot values are written to 41h–43h, then F1h/E0h. A second commit while busy produces no extra writes.
- Mode 0 commit, and commit held high for 10 cycles → no wr_req in the first case; exactly one sequence in the second.
- Reset asserted during WAIT of the second hour write → wr_req=0, busy=0 on the next edge; no seq_done; the next commit restarts from 21h.
- With CONTROLADOR_RTC_TIMEOUT_EN and TIMEOUT_CYCLES=16, driver never acks → wr_req drops 16 cycles after LOAD, seq_err=1, FSM in IDLE; a new commit clears seq_err.

Source files
------------

// File: rtl/controlador_escritura_rtc_pkg.sv
// Shared definitions for the RTC write controller: modes, states,
// register addresses, command bytes and the field snapshot bundle.
package controlador_escritura_rtc_pkg;

  typedef enum logic [1:0] {
    MODO_NORMAL = 2'd0,
    MODO_HORA   = 2'd1,
    MODO_FECHA  = 2'd2,
    MODO_TIMER  = 2'd3
  } modo_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CMD,
    S_CMD_WAIT,
    S_FIN
  } estado_t;

  localparam logic [7:0] DIR_SS   = 8'h21;
  localparam logic [7:0] DIR_MM   = 8'h22;
  localparam logic [7:0] DIR_HH   = 8'h23;
  localparam logic [7:0] DIR_DAY  = 8'h24;
  localparam logic [7:0] DIR_MES  = 8'h25;
  localparam logic [7:0] DIR_YEAR = 8'h26;
  localparam logic [7:0] DIR_DIA  = 8'h27;
  localparam logic [7:0] DIR_SS_T = 8'h41;
  localparam logic [7:0] DIR_MM_T = 8'h42;
  localparam logic [7:0] DIR_HH_T = 8'h43;

  localparam logic [7:0] CMD_ADDR_DEF       = 8'hF1;
  localparam logic [7:0] CMD_HORA_FECHA_DEF = 8'hD0;
  localparam logic [7:0] CMD_TIMER_DEF      = 8'hE0;
  localparam int unsigned TIMEOUT_DEF       = 1023;

  typedef struct packed {
    logic [7:0] ss;
    logic [7:0] mm;
    logic [7:0] hh;
    logic       am_pm;
    logic [7:0] day;
    logic [7:0] mes;
    logic [7:0] year;
    logic [7:0] dia;
    logic [7:0] ss_t;
    logic [7:0] mm_t;
    logic [7:0] hh_t;
  } campos_t;

endpackage

// File: rtl/controlador_escritura_rtc_secuencia.sv
// Combinational write table: (group, index) -> RTC address/data, last flag.
// Ports: grupo, indice, snap in; addr, data, last out.
module secuencia_escritura_rtc
  import controlador_escritura_rtc_pkg::*;
(
  input  modo_t       grupo,
  input  logic [1:0]  indice,
  input  campos_t     snap,
  output logic [7:0]  addr,
  output logic [7:0]  data,
  output logic        last
);

  // Only the 5 low hour bits go to the 12h register
  logic unused_hh;
  assign unused_hh = ^snap.hh[7:5];

  always_comb begin
    addr = '0;
    data = '0;
    last = 1'b0;
    unique case (1'b1)
      grupo == MODO_NORMAL: ;
      grupo == MODO_HORA: begin
        case (indice)
          2'd0: begin
            addr = DIR_SS;
            data = snap.ss;
          end
          2'd1: begin
            addr = DIR_MM;
            data = snap.mm;
          end
          default: begin
            addr = DIR_HH;
            // 12h mode flag, PM bit, hour
            data = {1'b1, 1'b0, snap.am_pm,
                    snap.hh[4:0]};
            last = 1'b1;
          end
        endcase
      end
      grupo == MODO_FECHA: begin
        case (indice)
          2'd0: begin
            addr = DIR_DAY;
            data = snap.day;
          end
          2'd1: begin
            addr = DIR_MES;
            data = snap.mes;
          end
          2'd2: begin
            addr = DIR_YEAR;
            data = snap.year;
          end
          default: begin
            addr = DIR_DIA;
            data = snap.dia;
            last = 1'b1;
          end
        endcase
      end
      grupo == MODO_TIMER: begin
        case (indice)
          2'd0: begin
            addr = DIR_SS_T;
            data = snap.ss_t;
          end
          2'd1: begin
            addr = DIR_MM_T;
            data = snap.mm_t;
          end
          default: begin
            addr = DIR_HH_T;
            data = snap.hh_t;
            last = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/controlador_escritura_rtc.sv
// RTC write sequencer: snapshots a config group on commit, writes each
// field, then the group transfer command. Handshake wr_req/wr_done.
// Ports: clk, reset, commit, config_mode, btn_data_* fields, AM_PM,
// dia_semana in; wr_req/wr_addr/wr_data, busy, seq_done, seq_err out.
// Optional watchdog: define CONTROLADOR_RTC_TIMEOUT_EN.
module controlador_escritura_rtc
  import controlador_escritura_rtc_pkg::*;
#(
  parameter logic [7:0]  CMD_ADDR       = CMD_ADDR_DEF,
  parameter logic [7:0]  CMD_HORA_FECHA = CMD_HORA_FECHA_DEF,
  parameter logic [7:0]  CMD_TIMER      = CMD_TIMER_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       commit,
  input  logic [1:0] config_mode,
  input  logic [7:0] btn_data_SS,
  input  logic [7:0] btn_data_MM,
  input  logic [7:0] btn_data_HH,
  input  logic       AM_PM,
  input  logic [7:0] btn_data_DAY,
  input  logic [7:0] btn_data_MES,
  input  logic [7:0] btn_data_YEAR,
  input  logic [7:0] dia_semana,
  input  logic [7:0] btn_data_SS_T,
  input  logic [7:0] btn_data_MM_T,
  input  logic [7:0] btn_data_HH_T,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_done,
  output logic       busy,
  output logic       seq_done,
  output logic       seq_err
);

  estado_t    estado_q, estado_d;
  modo_t      grupo_q;
  campos_t    snap_q, campos_in;
  logic [1:0] indice_q, indice_d;
  logic [7:0] addr_d, data_d;
  logic       commit_q, commit_tick;
  logic       acepta, timeout;
  logic [7:0] tab_addr, tab_data;
  logic       tab_last;

  assign commit_tick = commit & ~commit_q;
  assign acepta = (estado_q == S_IDLE) && commit_tick
               && (modo_t'(config_mode) != MODO_NORMAL);

  assign campos_in = '{
    ss:    btn_data_SS,
    mm:    btn_data_MM,
    hh:    btn_data_HH,
    am_pm: AM_PM,
    day:   btn_data_DAY,
    mes:   btn_data_MES,
    year:  btn_data_YEAR,
    dia:   dia_semana,
    ss_t:  btn_data_SS_T,
    mm_t:  btn_data_MM_T,
    hh_t:  btn_data_HH_T
  };

  secuencia_escritura_rtc u_tabla (
    .grupo  (grupo_q),
    .indice (indice_q),
    .snap   (snap_q),
    .addr   (tab_addr),
    .data   (tab_data),
    .last   (tab_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= S_IDLE;
      commit_q <= 1'b0;
      indice_q <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grupo_q  <= MODO_NORMAL;
      snap_q   <= '0;
    end else begin
      estado_q <= estado_d;
      commit_q <= commit;
      indice_q <= indice_d;
      wr_addr  <= addr_d;
      wr_data  <= data_d;
      if (acepta) begin
        grupo_q <= modo_t'(config_mode);
        snap_q  <= campos_in;
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      S_IDLE:
        if (acepta) estado_d = S_LOAD;
      S_LOAD:
        estado_d = S_WAIT;
      S_WAIT:
        if (wr_done)
          estado_d = tab_last ? S_CMD : S_LOAD;
        else if (timeout)
          estado_d = S_IDLE;
      S_CMD:
        estado_d = S_CMD_WAIT;
      S_CMD_WAIT:
        if (wr_done)
          estado_d = S_FIN;
        else if (timeout)
          estado_d = S_IDLE;
      S_FIN:
        estado_d = S_IDLE;
      default:
        estado_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = wr_addr;
    data_d   = wr_data;
    indice_d = indice_q;
    wr_req   = (estado_q == S_WAIT)
            || (estado_q == S_CMD_WAIT);
    busy     = (estado_q != S_IDLE)
            && (estado_q != S_FIN);
    seq_done = (estado_q == S_FIN);
    case (estado_q)
      S_LOAD: begin
        addr_d = tab_addr;
        data_d = tab_data;
      end
      S_WAIT:
        if (wr_done && !tab_last)
          indice_d = indice_q + 2'd1;
      S_CMD: begin
        addr_d = CMD_ADDR;
        data_d = (grupo_q == MODO_TIMER)
               ? CMD_TIMER : CMD_HORA_FECHA;
      end
      S_IDLE, S_FIN:
        indice_d = '0;
      default: ;
    endcase
  end

`ifdef CONTROLADOR_RTC_TIMEOUT_EN
  logic [9:0] cnt_q;
  logic       err_q;
  logic       en_espera;

  assign en_espera = (estado_q == S_WAIT)
                  || (estado_q == S_CMD_WAIT);
  assign timeout = en_espera && !wr_done
                && (cnt_q == 10'(TIMEOUT_CYCLES - 1));
  assign seq_err = err_q;

  // Counter restarts on every state change so each wait is timed alone
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (estado_d != estado_q)
        cnt_q <= '0;
      else if (en_espera)
        cnt_q <= cnt_q + 10'd1;
      if (acepta)
        err_q <= 1'b0;
      else if (timeout)
        err_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign seq_err = 1'b0;
`endif

endmodule
